// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared command encodings, FSM states and command record for the crossbar master
package xbar_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int XBAR_AW = 32;
    localparam int XBAR_DW = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RDATA,
        RESP,
        ERR
    } xbar_state_e;

    typedef struct packed {
        logic               write;
        logic [XBAR_AW-1:0] addr;
        logic [XBAR_DW-1:0] wdata;
    } xbar_cmd_t;

    function automatic xbar_cmd_t xbar_mk_cmd(input logic write, input logic [XBAR_AW-1:0] addr,
                                              input logic [XBAR_DW-1:0] wdata);
        xbar_cmd_t c;
        c.write = write;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/xbar_cmd_fifo.sv
// rtl/xbar_cmd_fifo.sv - synchronous command FIFO, no bypass, async active-low reset
module xbar_cmd_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/xbar_master.sv
// rtl/xbar_master.sv - crossbar initiator: queues commands, runs req/ack handshakes, returns one response each
module xbar_master
    import xbar_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic          cmd,
    output logic [DW-1:0] wdata,
    input  logic          ack,
    input  logic [DW-1:0] rdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          busy
);

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    xbar_state_e state;
    logic [CW-1:0] cnt;
    cmd_t       push_cmd;
    cmd_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign pop       = (state == IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    xbar_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req        <= 1'b0;
            addr       <= '0;
            cmd        <= 1'b0;
            wdata      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        addr  <= head.addr;
                        cmd   <= head.write;
                        wdata <= head.wdata;
                        req   <= 1'b1;
                        cnt   <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over an expiring timeout in the same cycle.
                    if (ack) begin
                        req        <= 1'b0;
                        resp_rdata <= '0;
                        state      <= (cmd == CMD_WRITE) ? RESP : RDATA;
                    end else if (cnt == CNT_LAST) begin
                        req   <= 1'b0;
                        state <= ERR;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RDATA: begin
                    resp_rdata <= rdata;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_master.sv
// tb/tb_xbar_master.sv - scoreboard bench for xbar_master with a single-register responder model
module tb_xbar_master;
    import xbar_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          req;
    logic [AW-1:0] addr;
    logic          cmd;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          busy;

    xbar_master #(
        .AW         (AW),
        .DW         (DW),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .req        (req),
        .addr       (addr),
        .cmd        (cmd),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int   resp_count = 0;
    int   resp_cyc = 0;
    int   req_rises = 0;
    int   req_high = 0;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (req && !req_prev) req_rises++;
            if (req) req_high++;
        end
        req_prev = req;
        if (reset_n && resp_valid) begin
            resp_count++;
            resp_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b, expected no response", resp_rdata, resp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (resp_rdata !== mon_e.rdata || resp_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL resp: got rdata=%h err=%b, expected rdata=%h err=%b",
                             resp_rdata, resp_err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    // Responder: acks on the second cycle of req; one data register shared by all addresses.
    logic          rsp_ack = 1'b0;
    logic          stray_ack = 1'b0;
    logic          dead = 1'b0;
    logic [DW-1:0] mem_q = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] cur_addr = '0;
    logic          last_valid = 1'b0;
    logic          in_req = 1'b0;
    int            req_cyc = 0;
    assign ack = rsp_ack | stray_ack;

    always @(negedge clk) begin
        rsp_ack = 1'b0;
        if (req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                req_cyc  = 0;
                cur_addr = addr;
            end
            req_cyc++;
            if (req_cyc == 2 && !dead && !(last_valid && cur_addr == last_addr)) begin
                rsp_ack = 1'b1;
                if (cmd) mem_q = wdata;
                else rdata = mem_q;
            end
        end else if (in_req) begin
            in_req     = 1'b0;
            last_addr  = cur_addr;
            last_valid = 1'b1;
        end
    end

    int accept_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input xbar_cmd_t c, input logic exp_en, input logic [DW-1:0] exp_rdata,
                        input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_accept: cmd_ready stayed 0 for addr %h", c.addr);
            cmd_valid = 1'b0;
            return;
        end
        if (exp_en) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_resp", 64'(resp_count >= target), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int a0;
        int rises0;
        int n;
        logic [DW-1:0] wd;

        repeat (3) @(negedge clk);
        check("rst_req", 64'(req), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Write then read; single-register responder returns the written word.
        base = resp_count;
        send(xbar_mk_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF), 1'b1, 32'h0, 1'b0);
        a0 = accept_cyc;
        wait_resp(base + 1);
        check("write_latency", 64'(resp_cyc - a0), 64'd4);
        send(xbar_mk_cmd(1'b0, 32'h0000_0020, 32'h0), 1'b1, 32'hDEAD_BEEF, 1'b0);
        a0 = accept_cyc;
        wait_resp(base + 2);
        check("read_latency", 64'(resp_cyc - a0), 64'd5);

        // Five back-to-back writes: FIFO fills while the first is in flight.
        idle(3);
        base   = resp_count;
        rises0 = req_rises;
        for (int a = 1; a <= 5; a++) begin
            wd = 32'h1111_1111 * 32'(a);
            send(xbar_mk_cmd(1'b1, 32'(a), wd), 1'b1, 32'h0, 1'b0);
            if (a == 4) check("ready_after_4", 64'(cmd_ready), 64'd1);
            if (a == 5) check("ready_after_5", 64'(cmd_ready), 64'd0);
        end
        wait_resp(base + 5);
        check("req_rises_5", 64'(req_rises - rises0), 64'd5);

        // Never-acking responder.
        idle(3);
        dead     = 1'b1;
        base     = resp_count;
        req_high = 0;
        send(xbar_mk_cmd(1'b0, 32'h0000_0300, 32'h0), 1'b1, 32'h0, 1'b1);
        wait_resp(base + 1);
        check("timeout_req_cycles", 64'(req_high), 64'(TO));
        dead = 1'b0;

        // Repeated address: second read is never acked.
        idle(3);
        base = resp_count;
        send(xbar_mk_cmd(1'b0, 32'h0000_0040, 32'h0), 1'b1, 32'h5555_5555, 1'b0);
        send(xbar_mk_cmd(1'b0, 32'h0000_0040, 32'h0), 1'b1, 32'h0, 1'b1);
        wait_resp(base + 2);

        // Reset during REQ with three commands queued.
        idle(3);
        dead = 1'b1;
        for (int i = 0; i < 4; i++)
            send(xbar_mk_cmd(1'b0, 32'h0000_0500 + 32'(i), 32'h0), 1'b0, 32'h0, 1'b0);
        idle(2);
        check("pre_reset_req", 64'(req), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_req_drop", 64'(req), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        dead    = 1'b0;
        base    = resp_count;
        idle(40);
        check("no_resp_after_reset", 64'(resp_count - base), 64'd0);
        check("busy_after_reset", 64'(busy), 64'd0);

        // Stray ack in IDLE, then in RESP.
        base = resp_count;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        idle(3);
        check("stray_idle_busy", 64'(busy), 64'd0);
        check("stray_idle_req", 64'(req), 64'd0);
        check("stray_idle_resp", 64'(resp_count - base), 64'd0);
        send(xbar_mk_cmd(1'b1, 32'h0000_0600, 32'hA5A5_0006), 1'b1, 32'h0, 1'b0);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            if (ack) break;
            n++;
        end
        check("ack_seen", 64'(n < 50), 64'd1);
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        wait_resp(base + 1);
        send(xbar_mk_cmd(1'b0, 32'h0000_0700, 32'h0), 1'b1, 32'hA5A5_0006, 1'b0);
        wait_resp(base + 2);
        idle(20);
        check("stray_resp_count", 64'(resp_count - base), 64'd2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
